// File: rtl/pio_bus_bridge.sv
// Register-slave front end for the pio core: decodes RP2040-style register offsets into
// single-cycle command strobes, captures read data, and shadows write-only configuration.
//
// state   | meaning
// S_IDLE  | waiting for req; decode and dispatch
// S_ISSUE | action strobe on the core command port for one cycle
// S_CAPTURE | core dout valid; latch into rdata
// S_STALL | target TX FIFO full; counting toward timeout
// S_ACK   | ack pulse; req ignored
module pio_bus_bridge #(
    parameter int NUM_MACHINES = 4,
    parameter int STALL_MAX    = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    req,
    input  logic                    we,
    input  logic [11:0]             addr,
    input  logic [31:0]             wdata,
    output logic                    ack,
    output logic                    err,
    output logic [31:0]             rdata,
    output logic [5:0]              action,
    output logic [1:0]              mindex,
    output logic [4:0]              index,
    output logic [31:0]             din,
    input  logic [31:0]             pio_dout,
    input  logic [NUM_MACHINES-1:0] tx_full,
    input  logic [NUM_MACHINES-1:0] rx_empty
);

    localparam int CW = $clog2(STALL_MAX + 1);

    localparam logic [5:0] ACT_NONE = 6'd0,  ACT_INSTR = 6'd1,  ACT_PEND = 6'd2,
                           ACT_PULL = 6'd3,  ACT_PUSH = 6'd4,   ACT_GRPS = 6'd5,
                           ACT_EN   = 6'd6,  ACT_DIV = 6'd7,    ACT_IMM = 6'd9,
                           ACT_SHIFT = 6'd10, ACT_RD_IRQ = 6'd11, ACT_RD_INTR = 6'd12,
                           ACT_RD_I0E = 6'd13, ACT_RD_I0F = 6'd14, ACT_RD_I0S = 6'd15,
                           ACT_RD_I1E = 6'd16, ACT_RD_I1F = 6'd17, ACT_RD_I1S = 6'd18,
                           ACT_WR_IRQ = 6'd19, ACT_WR_FORCE = 6'd20, ACT_WR_I0E = 6'd21,
                           ACT_WR_I0F = 6'd22, ACT_WR_I1E = 6'd23, ACT_WR_I1F = 6'd24;

    // Word addresses (byte offset >> 2)
    localparam logic [9:0] A_CTRL = 10'd0,  A_FSTAT = 10'd1, A_TXF = 10'd4, A_RXF = 10'd8,
                           A_IRQ = 10'd12,  A_FORCE = 10'd13,
                           A_IMEM_LO = 10'd18, A_IMEM_HI = 10'd49,
                           A_INTR = 10'd74, A_I0E = 10'd75, A_I0F = 10'd76, A_I0S = 10'd77,
                           A_I1E = 10'd78,  A_I1F = 10'd79, A_I1S = 10'd80;
    localparam int SM_BASE = 50;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_STALL, S_ACK} state_t;

    state_t          state, state_nx;
    logic [CW-1:0]   stall_cnt, cnt_nx;
    logic [3:0]      ctrl_shadow;
    logic [31:0]     sm_shadow [NUM_MACHINES][4];

    logic [9:0]      aw;
    logic            addr_unused;
    logic [3:0]      txf4, rxe4;
    logic [31:0]     fstat;

    logic            d_err, d_txf, d_rxf, d_ctrl_wr, d_sh_wr;
    logic [5:0]      d_code;
    logic [1:0]      d_n, d_slot, sm_n;
    logic [4:0]      d_index;
    logic [31:0]     d_din, d_rdata;
    logic            sm_hit;
    logic [2:0]      sm_reg;

    logic            ack_nx, err_nx, ctrl_we, sh_we;
    logic [31:0]     rdata_nx, din_nx;
    logic [5:0]      action_nx;
    logic [1:0]      mindex_nx;
    logic [4:0]      index_nx;

    assign aw          = addr[11:2];
    assign addr_unused = ^addr[1:0];
    assign txf4        = 4'(tx_full);
    assign rxe4        = 4'(rx_empty);
    assign fstat       = {12'b0, txf4, 4'b0, rxe4, 8'b0};

    always_comb begin
        d_err     = 1'b1;
        d_code    = ACT_NONE;
        d_txf     = 1'b0;
        d_rxf     = 1'b0;
        d_ctrl_wr = 1'b0;
        d_sh_wr   = 1'b0;
        d_slot    = 2'd0;
        d_n       = 2'd0;
        d_index   = 5'd0;
        d_din     = we ? wdata : 32'd0;
        d_rdata   = 32'd0;
        sm_hit    = 1'b0;
        sm_n      = 2'd0;
        sm_reg    = 3'd0;
        for (int i = 0; i < NUM_MACHINES; i++) begin
            if (aw >= 10'(SM_BASE + 6 * i) && aw < 10'(SM_BASE + 6 * i + 6)) begin
                sm_hit = 1'b1;
                sm_n   = 2'(i);
                sm_reg = 3'(aw - 10'(SM_BASE + 6 * i));
            end
        end

        if (aw == A_CTRL) begin
            d_err = 1'b0;
            if (we) begin
                d_code    = ACT_EN;
                d_ctrl_wr = 1'b1;
            end else begin
                d_rdata = {28'b0, ctrl_shadow};
            end
        end else if (aw == A_FSTAT) begin
            d_err = 1'b0;
            if (!we) d_rdata = fstat;
        end else if (aw >= A_TXF && aw < A_TXF + 10'(NUM_MACHINES)) begin
            if (we) begin
                d_err  = 1'b0;
                d_code = ACT_PUSH;
                d_txf  = 1'b1;
                d_n    = 2'(aw - A_TXF);
            end
        end else if (aw >= A_RXF && aw < A_RXF + 10'(NUM_MACHINES)) begin
            if (!we) begin
                d_err  = 1'b0;
                d_code = ACT_PULL;
                d_rxf  = 1'b1;
                d_n    = 2'(aw - A_RXF);
            end
        end else if (aw == A_IRQ) begin
            d_err  = 1'b0;
            d_code = we ? ACT_WR_IRQ : ACT_RD_IRQ;
        end else if (aw == A_FORCE) begin
            if (we) begin
                d_err  = 1'b0;
                d_code = ACT_WR_FORCE;
            end
        end else if (aw >= A_IMEM_LO && aw <= A_IMEM_HI) begin
            d_err = 1'b0;
            if (we) begin
                d_code  = ACT_INSTR;
                d_index = 5'(aw - A_IMEM_LO);
                d_din   = {16'b0, wdata[15:0]};
            end
        end else if (sm_hit) begin
            d_n = sm_n;
            case (sm_reg)
                3'd0: begin
                    d_err = 1'b0; d_slot = 2'd0; d_sh_wr = we;
                    if (we) begin
                        d_code = ACT_DIV;
                        d_din  = {8'b0, wdata[31:8]};
                    end else d_rdata = sm_shadow[sm_n][0];
                end
                3'd1: begin
                    d_err = 1'b0; d_slot = 2'd1; d_sh_wr = we;
                    if (we) d_code = ACT_PEND; else d_rdata = sm_shadow[sm_n][1];
                end
                3'd2: begin
                    d_err = 1'b0; d_slot = 2'd2; d_sh_wr = we;
                    if (we) d_code = ACT_SHIFT; else d_rdata = sm_shadow[sm_n][2];
                end
                3'd3: if (!we) d_err = 1'b0;
                3'd4: if (we) begin
                    d_err  = 1'b0;
                    d_code = ACT_IMM;
                end
                3'd5: begin
                    d_err = 1'b0; d_slot = 2'd3; d_sh_wr = we;
                    if (we) d_code = ACT_GRPS; else d_rdata = sm_shadow[sm_n][3];
                end
                default: d_err = 1'b1;
            endcase
        end else if (aw == A_INTR) begin
            if (!we) begin d_err = 1'b0; d_code = ACT_RD_INTR; end
        end else if (aw == A_I0E) begin
            d_err = 1'b0; d_code = we ? ACT_WR_I0E : ACT_RD_I0E;
        end else if (aw == A_I0F) begin
            d_err = 1'b0; d_code = we ? ACT_WR_I0F : ACT_RD_I0F;
        end else if (aw == A_I0S) begin
            if (!we) begin d_err = 1'b0; d_code = ACT_RD_I0S; end
        end else if (aw == A_I1E) begin
            d_err = 1'b0; d_code = we ? ACT_WR_I1E : ACT_RD_I1E;
        end else if (aw == A_I1F) begin
            d_err = 1'b0; d_code = we ? ACT_WR_I1F : ACT_RD_I1F;
        end else if (aw == A_I1S) begin
            if (!we) begin d_err = 1'b0; d_code = ACT_RD_I1S; end
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = stall_cnt;
        ack_nx    = 1'b0;
        err_nx    = err;
        rdata_nx  = rdata;
        action_nx = ACT_NONE;
        mindex_nx = mindex;
        index_nx  = index;
        din_nx    = din;
        ctrl_we   = 1'b0;
        sh_we     = 1'b0;
        case (state)
            S_IDLE: if (req) begin
                err_nx   = d_err;
                rdata_nx = d_rdata;
                ctrl_we  = !d_err && d_ctrl_wr;
                sh_we    = !d_err && d_sh_wr;
                if (d_err || d_code == ACT_NONE) begin
                    state_nx = S_ACK;
                    ack_nx   = 1'b1;
                end else if (d_txf && tx_full[d_n]) begin
                    state_nx = S_STALL;
                    cnt_nx   = '0;
                end else if (d_rxf && rx_empty[d_n]) begin
                    state_nx = S_ACK;
                    ack_nx   = 1'b1;
                end else begin
                    state_nx  = S_ISSUE;
                    action_nx = d_code;
                    mindex_nx = d_n;
                    index_nx  = d_index;
                    din_nx    = d_din;
                end
            end
            S_ISSUE: begin
                if (we) begin
                    state_nx = S_ACK;
                    ack_nx   = 1'b1;
                end else begin
                    state_nx = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                rdata_nx = pio_dout;
                state_nx = S_ACK;
                ack_nx   = 1'b1;
            end
            S_STALL: begin
                if (!tx_full[d_n]) begin
                    state_nx  = S_ISSUE;
                    action_nx = d_code;
                    mindex_nx = d_n;
                    index_nx  = d_index;
                    din_nx    = d_din;
                end else if (stall_cnt == CW'(STALL_MAX - 1)) begin
                    state_nx = S_ACK;
                    ack_nx   = 1'b1;
                    err_nx   = 1'b1;
                end else begin
                    cnt_nx = stall_cnt + CW'(1);
                end
            end
            S_ACK:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            stall_cnt   <= '0;
            ack         <= 1'b0;
            err         <= 1'b0;
            rdata       <= 32'd0;
            action      <= ACT_NONE;
            mindex      <= 2'd0;
            index       <= 5'd0;
            din         <= 32'd0;
            ctrl_shadow <= 4'd0;
            for (int i = 0; i < NUM_MACHINES; i++)
                for (int j = 0; j < 4; j++)
                    sm_shadow[i][j] <= 32'd0;
        end else begin
            state     <= state_nx;
            stall_cnt <= cnt_nx;
            ack       <= ack_nx;
            err       <= err_nx;
            rdata     <= rdata_nx;
            action    <= action_nx;
            mindex    <= mindex_nx;
            index     <= index_nx;
            din       <= din_nx;
            // restart bits of CTRL are pulses in the core and never read back
            if (ctrl_we) ctrl_shadow <= wdata[3:0];
            if (sh_we) sm_shadow[d_n][d_slot] <= wdata;
        end
    end

endmodule

// File: tb/tb_pio_bus_bridge.sv
// Directed bench for pio_bus_bridge: a default instance plus a STALL_MAX=8 instance
// sharing the same bus, used for the TX stall timeout case.
module tb_pio_bus_bridge;

    logic        clk = 1'b0;
    logic        reset, req, we;
    logic [11:0] addr;
    logic [31:0] wdata, pio_dout;
    logic [3:0]  tx_full, rx_empty;

    logic        ack, err, ack8, err8;
    logic [31:0] rdata, din, rdata8, din8;
    logic [5:0]  action, action8;
    logic [1:0]  mindex, mindex8;
    logic [4:0]  index, index8;

    int total = 0;
    int bad   = 0;
    int early = 0;

    always #5 clk = ~clk;

    pio_bus_bridge dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .action(action), .mindex(mindex),
        .index(index), .din(din), .pio_dout(pio_dout), .tx_full(tx_full), .rx_empty(rx_empty)
    );

    pio_bus_bridge #(.STALL_MAX(8)) dut8 (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .ack(ack8), .err(err8), .rdata(rdata8), .action(action8), .mindex(mindex8),
        .index(index8), .din(din8), .pio_dout(pio_dout), .tx_full(tx_full), .rx_empty(rx_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic w, input logic [11:0] a, input logic [31:0] d);
        req   = 1'b1;
        we    = w;
        addr  = a;
        wdata = d;
    endtask

    task automatic done_req();
        req = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        pio_dout = '0; tx_full = '0; rx_empty = '0;
        #2;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_action", 32'(action), 0);
        chk("rst_mindex", 32'(mindex), 0);
        chk("rst_index", 32'(index), 0);
        chk("rst_din", din, 0);
        tick(); tick();
        @(negedge clk) reset = 1'b1;
        tick();

        // CTRL write and readback of enable bits only
        start(1'b1, 12'h000, 32'h0000_0F15);
        tick();
        chk("ctrl_wr_action", 32'(action), 6);
        chk("ctrl_wr_din", din, 32'h0000_0F15);
        chk("ctrl_wr_early_ack", 32'(ack), 0);
        tick();
        chk("ctrl_wr_ack", 32'(ack), 1);
        chk("ctrl_wr_err", 32'(err), 0);
        chk("ctrl_wr_action_clr", 32'(action), 0);
        done_req();
        start(1'b0, 12'h000, 32'h0);
        tick();
        chk("ctrl_rd_ack", 32'(ack), 1);
        chk("ctrl_rd_rdata", rdata, 32'h5);
        chk("ctrl_rd_action", 32'(action), 0);
        done_req();

        // SM1 CLKDIV
        start(1'b1, 12'h0E0, 32'h0002_8000);
        tick();
        chk("clkdiv_action", 32'(action), 7);
        chk("clkdiv_mindex", 32'(mindex), 1);
        chk("clkdiv_din", din, 32'h0000_0280);
        tick();
        chk("clkdiv_ack", 32'(ack), 1);
        done_req();
        chk("clkdiv_din_hold", din, 32'h0000_0280);
        chk("clkdiv_mindex_hold", 32'(mindex), 1);
        start(1'b0, 12'h0E0, 32'h0);
        tick();
        chk("clkdiv_rd_ack", 32'(ack), 1);
        chk("clkdiv_rd_rdata", rdata, 32'h0002_8000);
        done_req();

        // RXF2 read through the core
        start(1'b0, 12'h028, 32'h0);
        tick();
        chk("rxf_action", 32'(action), 3);
        chk("rxf_mindex", 32'(mindex), 2);
        tick();
        pio_dout = 32'hDEAD_BEEF;
        chk("rxf_c2_ack", 32'(ack), 0);
        chk("rxf_c2_action", 32'(action), 0);
        tick();
        chk("rxf_ack", 32'(ack), 1);
        chk("rxf_rdata", rdata, 32'hDEAD_BEEF);
        done_req();
        pio_dout = 32'h0;

        rx_empty = 4'b0100;
        start(1'b0, 12'h028, 32'h0);
        tick();
        chk("rxf_empty_ack", 32'(ack), 1);
        chk("rxf_empty_rdata", rdata, 0);
        chk("rxf_empty_action", 32'(action), 0);
        done_req();
        rx_empty = 4'b0000;

        // TX stall timeout on the STALL_MAX=8 instance
        tx_full = 4'b0001;
        start(1'b1, 12'h010, 32'h1111_2222);
        early = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack8 !== 1'b0 || action8 !== 6'd0) early++;
        end
        chk("to_quiet_stall", 32'(early), 0);
        tick();
        chk("to_ack", 32'(ack8), 1);
        chk("to_err", 32'(err8), 1);
        chk("to_action", 32'(action8), 0);
        chk("to_rdata", rdata8, 0);
        chk("to_mindex_hold", 32'(mindex8), 2);
        chk("to_index_hold", 32'(index8), 0);
        chk("to_din_hold", din8, 0);
        req = 1'b0;
        tx_full = 4'b0000;
        repeat (4) tick();

        // TX stall released after 10 cycles
        tx_full = 4'b0001;
        start(1'b1, 12'h010, 32'hCAFE_F00D);
        early = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (ack !== 1'b0 || action !== 6'd0) early++;
        end
        chk("stall_quiet", 32'(early), 0);
        tx_full = 4'b0000;
        tick();
        chk("push_action", 32'(action), 4);
        chk("push_mindex", 32'(mindex), 0);
        chk("push_din", din, 32'hCAFE_F00D);
        tick();
        chk("push_ack", 32'(ack), 1);
        chk("push_err", 32'(err), 0);
        chk("push_single", 32'(action), 0);
        done_req();

        // INSTR_MEM slot 2
        start(1'b1, 12'h050, 32'h1234_E081);
        tick();
        chk("imem_action", 32'(action), 1);
        chk("imem_index", 32'(index), 2);
        chk("imem_din", din, 32'h0000_E081);
        tick();
        chk("imem_ack", 32'(ack), 1);
        done_req();

        start(1'b0, 12'h0E0, 32'h0);
        tick();
        chk("clkdiv_rd2_rdata", rdata, 32'h0002_8000);
        done_req();

        // Unmapped read, then an ignored FSTAT write that must clear err
        start(1'b0, 12'h200, 32'h0);
        tick();
        chk("bad_ack", 32'(ack), 1);
        chk("bad_err", 32'(err), 1);
        chk("bad_rdata", rdata, 0);
        chk("bad_action", 32'(action), 0);
        done_req();
        start(1'b1, 12'h004, 32'hFFFF_FFFF);
        tick();
        chk("fstat_wr_ack", 32'(ack), 1);
        chk("fstat_wr_err", 32'(err), 0);
        chk("fstat_wr_action", 32'(action), 0);
        done_req();

        // Reset during an issue cycle
        start(1'b0, 12'h024, 32'h0);
        tick();
        chk("rst_issue_pre", 32'(action), 3);
        reset = 1'b0;
        #1;
        chk("rst_issue_action", 32'(action), 0);
        chk("rst_issue_mindex", 32'(mindex), 0);
        req = 1'b0;
        @(negedge clk) reset = 1'b1;
        tick();

        // Reset during CAPTURE, with a non-zero CTRL shadow beforehand
        start(1'b1, 12'h000, 32'h0000_0003);
        tick(); tick();
        done_req();
        start(1'b0, 12'h024, 32'h0);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_cap_ack", 32'(ack), 0);
        chk("rst_cap_action", 32'(action), 0);
        chk("rst_cap_mindex", 32'(mindex), 0);
        req = 1'b0;
        repeat (2) tick();
        @(negedge clk) reset = 1'b1;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (ack !== 1'b0) early++;
        end
        chk("rst_cap_no_ack", 32'(early), 0);

        tx_full  = 4'b1010;
        rx_empty = 4'b0110;
        start(1'b0, 12'h004, 32'h0);
        tick();
        chk("fstat_ack", 32'(ack), 1);
        chk("fstat_err", 32'(err), 0);
        chk("fstat_rdata", rdata, 32'h000A_0600);
        done_req();
        start(1'b0, 12'h000, 32'h0);
        tick();
        chk("ctrl_after_rst", rdata, 0);
        done_req();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
